// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder over a word-wide backing store.
// RISC-V B/H/W accesses, with a programmable wait before each access.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 2048,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_wren_i,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);
    localparam int          IDXW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [IDXW-1:0]   idx_q;
    logic [1:0]        lane_q;
    logic              wren_q;
    logic [2:0]        op_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       rd_word_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic [31:0]       mem_q [DEPTH_WORDS];

    logic [31:0] offset_d;
    logic        req_err_d;
    logic [3:0]  be_d;
    logic [31:0] wword_d;
    logic [31:0] shifted_d;
    logic [31:0] load_ext_d;

    // Wrap-around of the subtraction makes addresses below BASE_ADDR fail too.
    assign offset_d = req_addr_i - BASE_ADDR;

    always_comb begin
        req_err_d = (offset_d >= SPAN);
        case (req_op_i)
            3'b000:  ;
            3'b001:  if (req_addr_i[0]) req_err_d = 1'b1;
            3'b010:  if (req_addr_i[1:0] != 2'b00) req_err_d = 1'b1;
            3'b100:  if (req_wren_i) req_err_d = 1'b1;
            3'b101:  if (req_wren_i || req_addr_i[0]) req_err_d = 1'b1;
            default: req_err_d = 1'b1;
        endcase
    end

    always_comb begin
        case (op_q[1:0])
            2'b00: begin
                be_d    = 4'b0001 << lane_q;
                wword_d = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {lane_q[1], 1'b0};
                wword_d = {2{wdata_q[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wword_d = wdata_q;
            end
        endcase
    end

    assign shifted_d = rd_word_q >> {lane_q, 3'b000};

    always_comb begin
        case (op_q)
            3'b000:  load_ext_d = {{24{shifted_d[7]}}, shifted_d[7:0]};
            3'b001:  load_ext_d = {{16{shifted_d[15]}}, shifted_d[15:0]};
            3'b100:  load_ext_d = {24'h0, shifted_d[7:0]};
            3'b101:  load_ext_d = {16'h0, shifted_d[15:0]};
            default: load_ext_d = shifted_d;
        endcase
    end

    // Registered-read storage; the read word feeds the extract in the first RESP cycle.
    always_ff @(posedge clk_i) begin
        if (state_q == S_ACCESS && wren_q) begin
            for (int l = 0; l < 4; l++) begin
                if (be_d[l]) mem_q[idx_q][l*8 +: 8] <= wword_d[l*8 +: 8];
            end
        end
        rd_word_q <= mem_q[idx_q];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            lane_q      <= 2'd0;
            wren_q      <= 1'b0;
            op_q        <= 3'd0;
            wdata_q     <= 32'd0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        idx_q   <= offset_d[IDXW+1:2];
                        lane_q  <= req_addr_i[1:0];
                        wren_q  <= req_wren_i;
                        op_q    <= req_op_i;
                        wdata_q <= req_wdata_i;
                        err_q   <= req_err_d;
                        if (req_err_d) begin
                            state_q <= S_RESP;
                        end else if (WAIT_CYCLES == 0) begin
                            state_q <= S_ACCESS;
                        end else begin
                            cnt_q   <= 4'(WAIT_CYCLES);
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= S_ACCESS;
                end
                S_ACCESS: state_q <= S_RESP;
                S_RESP: begin
                    // First RESP cycle builds the response; later cycles hold it.
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                        rsp_rdata_q <= (err_q || wren_q) ? 32'd0 : load_ext_d;
                    end else if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: data, extension, latency, errors,
// backpressure and reset abandonment.
module tb_dmem_responder;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = 32'd0;
    logic        req_wren_i = 1'b0;
    logic [2:0]  req_op_i = 3'd0;
    logic [31:0] req_wdata_i = 32'd0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    int checks = 0;
    int failures = 0;

    dmem_responder dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_wren_i  (req_wren_i),
        .req_op_i    (req_op_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One request; hold > 0 stalls the response and pokes req_valid_i meanwhile.
    task automatic xact(input string tag, input logic [31:0] a, input logic w,
                        input logic [2:0] op, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e,
                        input int exp_lat, input int hold);
        int n;
        @(negedge clk_i);
        chk({tag, ".ready"}, 32'(req_ready_o), 32'd1);
        rsp_ready_i = (hold == 0);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_wren_i  = w;
        req_op_i    = op;
        req_wdata_i = wd;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        n = 0;
        while (n < 50) begin
            @(posedge clk_i);
            n++;
            #1;
            if (rsp_valid_o) break;
        end
        chk({tag, ".lat"}, 32'(n), 32'(exp_lat));
        chk({tag, ".rdata"}, rsp_rdata_o, exp_d);
        chk({tag, ".err"}, 32'(rsp_err_o), 32'(exp_e));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i);
            #1;
            chk({tag, ".hold_valid"}, 32'(rsp_valid_o), 32'd1);
            chk({tag, ".hold_rdata"}, rsp_rdata_o, exp_d);
            chk({tag, ".hold_err"}, 32'(rsp_err_o), 32'(exp_e));
            chk({tag, ".hold_ready"}, 32'(req_ready_o), 32'd0);
            if (i == 3) begin
                req_valid_i = 1'b1;
                req_addr_i  = 32'h0000_2004;
                req_wren_i  = 1'b1;
                req_op_i    = 3'b010;
                req_wdata_i = 32'h0BAD_F00D;
            end else begin
                req_valid_i = 1'b0;
            end
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk({tag, ".drop_valid"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, ".idle_ready"}, 32'(req_ready_o), 32'd1);
        $display("xact %s addr=%08h wr=%0d op=%03b rdata=%08h err=%0d lat=%0d",
                 tag, a, w, op, exp_d, exp_e, n);
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst.valid", 32'(rsp_valid_o), 32'd0);
        chk("rst.rdata", rsp_rdata_o, 32'd0);
        chk("rst.err", 32'(rsp_err_o), 32'd0);
        @(negedge clk_i) rst_ni = 1'b1;
        #1 chk("rst.ready", 32'(req_ready_o), 32'd1);

        xact("sw_2004", 32'h2004, 1'b1, 3'b010, 32'hDEAD_BEEF, 32'h0, 1'b0, 4, 0);
        xact("lw_2004", 32'h2004, 1'b0, 3'b010, 32'h0, 32'hDEAD_BEEF, 1'b0, 4, 0);
        xact("lb_2007", 32'h2007, 1'b0, 3'b000, 32'h0, 32'hFFFF_FFDE, 1'b0, 4, 0);
        xact("lbu_2007", 32'h2007, 1'b0, 3'b100, 32'h0, 32'h0000_00DE, 1'b0, 4, 0);
        xact("lh_2004", 32'h2004, 1'b0, 3'b001, 32'h0, 32'hFFFF_BEEF, 1'b0, 4, 0);
        xact("lhu_2006", 32'h2006, 1'b0, 3'b101, 32'h0, 32'h0000_DEAD, 1'b0, 4, 0);

        xact("sb_2005", 32'h2005, 1'b1, 3'b000, 32'hFFFF_FF55, 32'h0, 1'b0, 4, 0);
        xact("lw_after_sb", 32'h2004, 1'b0, 3'b010, 32'h0, 32'hDEAD_55EF, 1'b0, 4, 0);
        xact("sh_2006", 32'h2006, 1'b1, 3'b001, 32'hABCD_1234, 32'h0, 1'b0, 4, 0);
        xact("lw_after_sh", 32'h2004, 1'b0, 3'b010, 32'h0, 32'h1234_55EF, 1'b0, 4, 0);

        xact("err_misalign", 32'h2002, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1, 0);
        xact("err_below", 32'h1FFC, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1, 0);
        xact("err_above", 32'h4000, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1, 0);
        xact("err_op011", 32'h2004, 1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 1, 0);
        xact("err_lh_odd", 32'h2005, 1'b0, 3'b001, 32'h0, 32'h0, 1'b1, 1, 0);
        xact("err_st_bu", 32'h2004, 1'b1, 3'b100, 32'h0, 32'h0, 1'b1, 1, 0);
        xact("err_sw_2006", 32'h2006, 1'b1, 3'b010, 32'h7777_7777, 32'h0, 1'b1, 1, 0);
        xact("lw_unchanged", 32'h2004, 1'b0, 3'b010, 32'h0, 32'h1234_55EF, 1'b0, 4, 0);

        xact("sw_top", 32'h3FFC, 1'b1, 3'b010, 32'hCAFE_F00D, 32'h0, 1'b0, 4, 0);
        xact("lw_top", 32'h3FFC, 1'b0, 3'b010, 32'h0, 32'hCAFE_F00D, 1'b0, 4, 0);

        xact("lw_backpressure", 32'h2004, 1'b0, 3'b010, 32'h0, 32'h1234_55EF, 1'b0, 4, 10);
        xact("lw_no_poke", 32'h2004, 1'b0, 3'b010, 32'h0, 32'h1234_55EF, 1'b0, 4, 0);

        xact("sw_2010_prior", 32'h2010, 1'b1, 3'b010, 32'h1111_2222, 32'h0, 1'b0, 4, 0);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_addr_i  = 32'h2010;
        req_wren_i  = 1'b1;
        req_op_i    = 3'b010;
        req_wdata_i = 32'hA5A5_A5A5;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1 chk("midrst.valid", 32'(rsp_valid_o), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i);
            #1 if (rsp_valid_o) seen = 1;
        end
        chk("midrst.no_rsp", 32'(seen), 32'd0);
        chk("midrst.ready", 32'(req_ready_o), 32'd1);
        $display("xact midrst addr=00002010 wr=1 op=010 abandoned");
        xact("lw_2010_prior", 32'h2010, 1'b0, 3'b010, 32'h0, 32'h1111_2222, 1'b0, 4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
